core_memory_responder: RTL and testbench

- Downstream stage of the core-internal memory multiplexer. It consumes the request packets the multiplexer places on its output bus.
- Services each request against a local word-addressed RAM.
- Returns a response packet whose source field is unchanged, so the multiplexer can route it back to fetch or the other requester.
- Serviced requests are strictly one at a time and in order, with a programmable access latency.

---
 rtl/mem_bus_pkg.sv | 35 +++
 rtl/core_memory_ram.sv | 31 +++
 rtl/core_memory_responder.sv | 127 ++++++++++++
 tb/tb_core_memory_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the core-internal memory bus: command codes,
// component ids, packet layout and the responder state encoding.
package mem_bus_pkg;

  localparam int BUS_DATA_W = 64;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_SRC_W  = 4;

  localparam logic [1:0] CMD_READ   = 2'd0;
  localparam logic [1:0] CMD_WRITE  = 2'd1;
  localparam logic [1:0] CMD_RSVD_2 = 2'd2;
  localparam logic [1:0] CMD_RSVD_3 = 2'd3;

  localparam logic [BUS_SRC_W-1:0] COMPONENT_TYPE_FETCH = 4'd0;
  localparam logic [BUS_SRC_W-1:0] COMPONENT_TYPE_LSU   = 4'd1;
  localparam logic [BUS_SRC_W-1:0] COMPONENT_TYPE_MMU   = 4'd2;

  typedef struct packed {
    logic [1:0]            cmd;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] data;
    logic [BUS_SRC_W-1:0]  src;
  } mem_packet_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } resp_state_t;

  function automatic logic cmd_is_valid(input logic [1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/core_memory_ram.sv
// Single-port synchronous RAM with write enable and registered read.
// No reset on the array or read register so it maps onto block RAM.
module core_memory_ram
  import mem_bus_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_reg[addr] <= wdata;
      end
      rdata_reg <= mem_reg[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/core_memory_responder.sv
// Services memory-bus request packets one at a time against a local RAM
// and returns a response packet carrying the original source id.
module core_memory_responder
  import mem_bus_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int SRC_W     = 4,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_busy,
  output logic              req_accept,
  input  logic [1:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [SRC_W-1:0]  req_src,
  output logic              resp_busy,
  input  logic              resp_taken,
  output logic [1:0]        resp_cmd,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DATA_W-1:0] resp_data,
  output logic [SRC_W-1:0]  resp_src,
  output logic              resp_error
);

  localparam int OFS_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(MEM_WORDS);

  resp_state_t       state_reg;
  logic [3:0]        cnt_reg;
  logic [DATA_W-1:0] data_reg;
  logic              rd_sel_reg;

  logic [IDX_W-1:0]  idx;
  logic              out_of_range;
  logic              req_ok;
  logic              do_access;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // Decode works on the latched address so the requester may drop its packet.
  assign idx = resp_addr[OFS_W +: IDX_W];

  generate
    if (OFS_W + IDX_W < ADDR_W) begin : g_range
      assign out_of_range = |resp_addr[ADDR_W-1:OFS_W+IDX_W];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign req_ok     = cmd_is_valid(resp_cmd) && !out_of_range;
  assign do_access  = (state_reg == ST_ACCESS) && (cnt_reg == 4'd1);
  assign ram_en     = do_access && req_ok;
  assign ram_we     = ram_en && (resp_cmd == CMD_WRITE);
  assign req_accept = (state_reg == ST_IDLE) && req_busy && !reset;

  // RAM read data stays put after the access because the RAM is only enabled then.
  assign resp_data  = rd_sel_reg ? ram_rdata : data_reg;

  core_memory_ram #(
    .WIDTH(DATA_W),
    .DEPTH(MEM_WORDS)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (idx),
    .wdata(data_reg),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 4'd0;
      data_reg   <= '0;
      rd_sel_reg <= 1'b0;
      resp_busy  <= 1'b0;
      resp_error <= 1'b0;
      resp_cmd   <= 2'd0;
      resp_addr  <= '0;
      resp_src   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_busy) begin
            resp_cmd   <= req_cmd;
            resp_addr  <= req_addr;
            resp_src   <= req_src;
            data_reg   <= req_data;
            rd_sel_reg <= 1'b0;
            cnt_reg    <= 4'(LATENCY);
            state_reg  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            resp_error <= !req_ok;
            rd_sel_reg <= ram_en && !ram_we;
            if (!req_ok) begin
              data_reg <= '0;
            end
            resp_busy <= 1'b1;
            state_reg <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (resp_taken) begin
            resp_busy <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          resp_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_memory_responder.sv
// Directed bench for core_memory_responder: latency, decode errors,
// back-pressure, reset abort and read-after-write ordering.
module tb_core_memory_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_busy = 1'b0;
  logic        req_accept;
  logic [1:0]  req_cmd = 2'd0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_src = '0;
  logic        resp_busy;
  logic        resp_taken = 1'b0;
  logic [1:0]  resp_cmd;
  logic [31:0] resp_addr;
  logic [63:0] resp_data;
  logic [3:0]  resp_src;
  logic        resp_error;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  core_memory_responder #(
    .DATA_W(64), .ADDR_W(32), .SRC_W(4), .MEM_WORDS(1024), .LATENCY(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_busy  (req_busy),
    .req_accept(req_accept),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_src   (req_src),
    .resp_busy (resp_busy),
    .resp_taken(resp_taken),
    .resp_cmd  (resp_cmd),
    .resp_addr (resp_addr),
    .resp_data (resp_data),
    .resp_src  (resp_src),
    .resp_error(resp_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [63:0] data, input logic [3:0] src);
    req_cmd  = cmd;
    req_addr = addr;
    req_data = data;
    req_src  = src;
    req_busy = 1'b1;
  endtask

  // Called with the accept cycle just sampled; runs the rest of the transaction.
  task automatic finish_txn(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                            input logic [3:0] src, input logic [63:0] exp_data,
                            input logic exp_err);
    int lat;
    @(negedge clk);
    check({tag, "_acc_pulse"}, {63'd0, req_accept}, 64'd0);
    req_busy = 1'b0;
    lat = 1;
    while (!resp_busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_data"}, resp_data, exp_data);
    check({tag, "_err"}, {63'd0, resp_error}, {63'd0, exp_err});
    check({tag, "_src"}, {60'd0, resp_src}, {60'd0, src});
    check({tag, "_cmd"}, {62'd0, resp_cmd}, {62'd0, cmd});
    check({tag, "_addr"}, {32'd0, resp_addr}, {32'd0, addr});
    $display("txn %s cmd=%0d addr=%h src=%0d data=%h err=%0b lat=%0d",
             tag, resp_cmd, resp_addr, resp_src, resp_data, resp_error, lat);
    resp_taken = 1'b1;
    @(negedge clk);
    check({tag, "_busy_drop"}, {63'd0, resp_busy}, 64'd0);
    resp_taken = 1'b0;
  endtask

  task automatic do_txn(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [63:0] data, input logic [3:0] src,
                        input logic [63:0] exp_data, input logic exp_err);
    int w;
    drive_req(cmd, addr, data, src);
    #1;
    w = 0;
    while (!req_accept && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check({tag, "_accept"}, {63'd0, req_accept}, 64'd1);
    finish_txn(tag, cmd, addr, src, exp_data, exp_err);
  endtask

  initial begin
    int acc_seen;
    logic [63:0] held_data;

    // Reset with a request already pending: nothing may be accepted.
    drive_req(2'd1, 32'h10, 64'h1, 4'd1);
    @(negedge clk);
    check("rst_accept", {63'd0, req_accept}, 64'd0);
    check("rst_busy", {63'd0, resp_busy}, 64'd0);
    check("rst_err", {63'd0, resp_error}, 64'd0);
    check("rst_data", resp_data, 64'd0);
    check("rst_src", {60'd0, resp_src}, 64'd0);
    req_busy = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    $display("txn reset released");

    do_txn("wr10", 2'd1, 32'h10, 64'hDEADBEEF, 4'd1, 64'hDEADBEEF, 1'b0);
    do_txn("rd10", 2'd0, 32'h10, 64'h0, 4'd0, 64'hDEADBEEF, 1'b0);
    do_txn("wr00", 2'd1, 32'h0, 64'h0123456789ABCDEF, 4'd2, 64'h0123456789ABCDEF, 1'b0);
    do_txn("rd2000", 2'd0, 32'h2000, 64'h0, 4'd2, 64'h0, 1'b1);
    do_txn("rd00", 2'd0, 32'h0, 64'h0, 4'd2, 64'h0123456789ABCDEF, 1'b0);

    // Back-pressure: response held 5 cycles while a second request waits.
    drive_req(2'd0, 32'h10, 64'h0, 4'd3);
    #1;
    check("bp_acc1", {63'd0, req_accept}, 64'd1);
    @(negedge clk);
    drive_req(2'd0, 32'h0, 64'h0, 4'd5);
    acc_seen = 0;
    held_data = '0;
    for (int i = 1; i <= 7; i++) begin
      if (req_accept) acc_seen++;
      if (i == 3) held_data = resp_data;
      if (i < 7) @(negedge clk);
    end
    check("bp_no_accept", 64'(acc_seen), 64'd0);
    check("bp_busy_held", {63'd0, resp_busy}, 64'd1);
    check("bp_data_first", held_data, 64'hDEADBEEF);
    check("bp_data_stable", resp_data, 64'hDEADBEEF);
    check("bp_src_stable", {60'd0, resp_src}, 64'd3);
    @(negedge clk);
    check("bp_no_accept_tk", {63'd0, req_accept}, 64'd0);
    resp_taken = 1'b1;
    @(negedge clk);
    resp_taken = 1'b0;
    check("bp_acc2", {63'd0, req_accept}, 64'd1);
    check("bp_busy_low", {63'd0, resp_busy}, 64'd0);
    $display("txn bp first response held, second accepted");
    finish_txn("bp_rd00", 2'd0, 32'h0, 4'd5, 64'h0123456789ABCDEF, 1'b0);

    // Reset in the access cycle of a WRITE must abort it.
    do_txn("wr18", 2'd1, 32'h18, 64'h1111, 4'd1, 64'h1111, 1'b0);
    drive_req(2'd1, 32'h18, 64'h55, 4'd1);
    #1;
    check("abort_accept", {63'd0, req_accept}, 64'd1);
    @(negedge clk);
    req_busy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, resp_busy}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset during ACCESS of write 0x18");
    do_txn("rd18", 2'd0, 32'h18, 64'h0, 4'd1, 64'h1111, 1'b0);

    // Reset while a response is pending clears it at once.
    drive_req(2'd0, 32'h10, 64'h0, 4'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_busy = 1'b0;
    end
    check("rsp_rst_pre", {63'd0, resp_busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("rsp_rst_busy", {63'd0, resp_busy}, 64'd0);
    check("rsp_rst_data", resp_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset during RESPOND");

    do_txn("cmd3", 2'd3, 32'h10, 64'h99, 4'd6, 64'h0, 1'b1);
    do_txn("rd10b", 2'd0, 32'h10, 64'h0, 4'd0, 64'hDEADBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
